// File: rtl/mult_pkg.sv
// Shared definitions for the shared-multiplier arbiter: controller states and
// the default operand width.
package mult_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/array_multiplier.sv
// Unsigned combinational array multiplier: exact 2*N-bit product of two N-bit operands.
module array_multiplier
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  logic [2*N-1:0] w_a_ext;

  assign w_a_ext = {{N{1'b0}}, i_a};

  // One shifted partial-product row per multiplier bit.
  always_comb begin
    o_p = '0;
    for (int i = 0; i < N; i++) begin
      if (i_b[i]) o_p = o_p + (w_a_ext << i);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Two requesters share a single array multiplier; round-robin grant, one
// operation in flight, result held until the consumer takes it.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [N-1:0]   a0_i,
  input  logic [N-1:0]   b0_i,
  input  logic [N-1:0]   a1_i,
  input  logic [N-1:0]   b1_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [2*N-1:0] rsp_product_o,
  output logic           rsp_id_o,
  output logic           busy_o
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_id;
  logic           r_last_grant;
  logic [2*N-1:0] r_product;
  logic [2*N-1:0] w_mult_p;
  logic [1:0]     w_grant;
  logic           w_accept;
  logic           w_sel;

  // Grant is recomputed every cycle from live valids; nothing is latched until accept.
  always_comb begin
    w_grant = req_valid_i;
    if (req_valid_i == 2'b11) w_grant = r_last_grant ? 2'b01 : 2'b10;
  end

  assign w_accept = |(req_valid_i & req_ready_o);
  assign w_sel    = req_ready_o[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    w_state_nxt = HOLD;
      HOLD:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 2'b00;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      IDLE: begin
        req_ready_o = w_grant;
        busy_o      = 1'b0;
      end
      HOLD:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_product    <= '0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_a          <= w_sel ? a1_i : a0_i;
        r_b          <= w_sel ? b1_i : b0_i;
        r_id         <= w_sel;
        r_last_grant <= w_sel;
      end
      if (r_state == CALC) r_product <= w_mult_p;
    end
  end

  array_multiplier #(
    .N (N)
  ) u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_mult_p)
  );

  assign rsp_product_o = r_product;
  assign rsp_id_o      = r_id;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter; expected responses are queued at
// accept time and compared by a response monitor at handshake time.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [1:0]     req_valid_i;
  logic [1:0]     req_ready_o;
  logic [N-1:0]   a0_i, b0_i, a1_i, b1_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [2*N-1:0] rsp_product_o;
  logic           rsp_id_o;
  logic           busy_o;

  typedef struct {
    logic [2*N-1:0] prod;
    logic           id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic lg_model;

  always #5 clk_i = ~clk_i;

  mult_share_arbiter #(.N(N)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .a0_i          (a0_i),
    .b0_i          (b0_i),
    .a1_i          (a1_i),
    .b1_i          (b1_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_product_o (rsp_product_o),
    .rsp_id_o      (rsp_id_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Response monitor: a handshake happens on the next rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_rsp observed_product=%0d expected=no_response", rsp_product_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_product", 32'(rsp_product_o), 32'(e.prod));
        check("rsp_id", 32'(rsp_id_o), 32'(e.id));
      end
    end
  end

  // Advance to the drive point just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic lg);
    if (v == 2'b11) return lg ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic push_accept(input logic [1:0] v);
    logic [1:0] g;
    exp_t e;
    g = model_grant(v, lg_model);
    check("req_ready", 32'(req_ready_o), 32'(g));
    e.id   = g[1];
    e.prod = g[1] ? (2*N)'(a1_i) * (2*N)'(b1_i) : (2*N)'(a0_i) * (2*N)'(b0_i);
    sb.push_back(e);
    lg_model = g[1];
  endtask

  // Single request from requester k, with `stall` cycles of backpressure in HOLD.
  task automatic run_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
    logic [2*N-1:0] exp_p;
    exp_p = (2*N)'(a) * (2*N)'(b);
    if (k == 0) begin a0_i = a; b0_i = b; req_valid_i = 2'b01; end
    else        begin a1_i = a; b1_i = b; req_valid_i = 2'b10; end
    rsp_ready_i = (stall == 0);
    #1;
    push_accept(req_valid_i);
    cyc();
    req_valid_i = 2'b00;
    #1;
    check("calc_busy", 32'(busy_o), 32'd1);
    check("calc_rsp_valid", 32'(rsp_valid_o), 32'd0);
    cyc();
    #1;
    check("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(rsp_valid_o), 32'd1);
      check("stall_product", 32'(rsp_product_o), 32'(exp_p));
      check("stall_id", 32'(rsp_id_o), 32'(k));
      check("stall_ready", 32'(req_ready_o), 32'd0);
      cyc();
    end
    rsp_ready_i = 1'b1;
    cyc();
    #1;
    check("back_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_product"}, 32'(rsp_product_o), 32'd0);
    check({tag, "_id"}, 32'(rsp_id_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b0;
    a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
    lg_model    = 1'b1;
    #1;
    check_reset_outputs("por");
    check("por_ready", 32'(req_ready_o), 32'd0);
    cyc();
    rst_ni = 1'b1;

    // Single request, consumer always ready.
    run_op(0, 4'd3, 4'd5, 0);

    // Contention from a fresh reset: grants alternate 0,1,0,1 every 3 cycles.
    rst_ni = 1'b0;
    #1;
    lg_model = 1'b1;
    cyc();
    rst_ni      = 1'b1;
    a0_i = 4'd2;  b0_i = 4'd7;
    a1_i = 4'd15; b1_i = 4'd15;
    req_valid_i = 2'b11;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_grant", 32'(req_ready_o), (i % 2 == 0) ? 32'd1 : 32'd2);
      push_accept(req_valid_i);
      cyc();
      #1;
      check("cont_calc_ready", 32'(req_ready_o), 32'd0);
      cyc();
      #1;
      check("cont_hold_ready", 32'(req_ready_o), 32'd0);
      cyc();
    end
    req_valid_i = 2'b00;
    #1;
    check("cont_drained", 32'(sb.size()), 32'd0);

    // Backpressure on requester 1.
    run_op(1, 4'd9, 4'd4, 5);

    // Reset during CALC discards the operation.
    a0_i = 4'd6; b0_i = 4'd6;
    req_valid_i = 2'b01;
    rsp_ready_i = 1'b1;
    #1;
    push_accept(req_valid_i);
    cyc();
    req_valid_i = 2'b00;
    #1;
    check("midop_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midop");
    check("midop_ready", 32'(req_ready_o), 32'd0);
    sb.delete();
    lg_model = 1'b1;
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_quiet", 32'(rsp_valid_o), 32'd0);
      cyc();
    end
    run_op(0, 4'd6, 4'd6, 0);

    // Withdrawal: requester 1 raises and drops valid while block is in HOLD.
    a0_i = 4'd5; b0_i = 4'd3;
    req_valid_i = 2'b01;
    rsp_ready_i = 1'b0;
    #1;
    push_accept(req_valid_i);
    cyc();
    req_valid_i = 2'b00;
    cyc();
    a1_i = 4'd1; b1_i = 4'd1;
    req_valid_i = 2'b10;
    #1;
    check("wd_hold_ready", 32'(req_ready_o), 32'd0);
    cyc();
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    #1;
    check("wd_ready_after_drop", 32'(req_ready_o), 32'd0);
    cyc();
    #1;
    check("wd_idle_ready", 32'(req_ready_o), 32'd0);
    // last_grant must still be 0, so contention now goes to requester 1.
    a0_i = 4'd4; b0_i = 4'd4;
    a1_i = 4'd7; b1_i = 4'd8;
    req_valid_i = 2'b11;
    #1;
    check("wd_lastgrant", 32'(req_ready_o), 32'd2);
    push_accept(req_valid_i);
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();

    // Exhaustive operand sweep through requester 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(0, N'(a), N'(b), 0);
      end
    end

    rsp_ready_i = 1'b0;
    cyc();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
